nmr_bstrm_sram_arb: RTL and testbench

NMR_BSTRM_SRAM_ARB -- requirements
Module: nmr_bstrm_sram_arb

---
 rtl/nmr_bstrm_sram_arb.sv | 197 +++++++++++++++++++
 tb/tb_nmr_bstrm_sram_arb.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nmr_bstrm_sram_arb.sv
// Command-SRAM arbiter between the host access port and the bitstream engine fetch port.
// One transaction in flight, round-robin on contention, host writes locked out while RUN.
module nmr_bstrm_sram_arb #(
   parameter int SRAM_ADDR_WIDTH   = 8,
   parameter int SRAM_DAT_WIDTH    = 128,
   parameter int SRAM_BYTEEN_WIDTH = 16,
   parameter int RD_LAT            = 2
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         RUN,
   input  logic                         HOST_REQ,
   input  logic                         HOST_WR,
   input  logic [SRAM_ADDR_WIDTH-1:0]   HOST_ADDR,
   input  logic [SRAM_DAT_WIDTH-1:0]    HOST_WR_DAT,
   input  logic [SRAM_BYTEEN_WIDTH-1:0] HOST_BYTEEN,
   output logic                         HOST_GNT,
   output logic                         HOST_ERR,
   output logic                         HOST_RD_VALID,
   output logic [SRAM_DAT_WIDTH-1:0]    HOST_RD_DAT,
   input  logic                         ENG_REQ,
   input  logic [SRAM_ADDR_WIDTH-1:0]   ENG_ADDR,
   output logic                         ENG_ACK,
   output logic [SRAM_DAT_WIDTH-1:0]    ENG_RD_DAT,
   output logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR,
   output logic                         SRAM_CS,
   output logic                         SRAM_CLKEN,
   output logic                         SRAM_WR,
   output logic [SRAM_DAT_WIDTH-1:0]    SRAM_WR_DAT,
   output logic [SRAM_BYTEEN_WIDTH-1:0] SRAM_BYTEEN,
   input  logic [SRAM_DAT_WIDTH-1:0]    SRAM_RD_DAT
);

   typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;

   // RD_WAIT lasts RD_LAT cycles; the counter loads RD_LAT-1 and captures at zero.
   localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

   state_t state_q, state_d;

   logic [1:0]                   cnt_q, cnt_d;
   logic                         owner_eng_q, owner_eng_d;
   logic                         last_host_q, last_host_d;
   logic                         eng_elig_q, eng_elig_d;
   logic [SRAM_ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
   logic                         sram_cs_q, sram_cs_d;
   logic                         sram_wr_q, sram_wr_d;
   logic [SRAM_DAT_WIDTH-1:0]    sram_wr_dat_q, sram_wr_dat_d;
   logic [SRAM_BYTEEN_WIDTH-1:0] sram_byteen_q, sram_byteen_d;
   logic                         host_gnt_q, host_gnt_d;
   logic                         host_err_q, host_err_d;
   logic                         host_rd_valid_q, host_rd_valid_d;
   logic [SRAM_DAT_WIDTH-1:0]    host_rd_dat_q, host_rd_dat_d;
   logic                         eng_ack_q, eng_ack_d;
   logic [SRAM_DAT_WIDTH-1:0]    eng_rd_dat_q, eng_rd_dat_d;

   logic eng_pend, pick_eng, pick_host, host_rej;

   // Engine only competes once ENG_REQ has dropped since its last ACK.
   assign eng_pend  = ENG_REQ & eng_elig_q;
   assign pick_eng  = eng_pend & (~HOST_REQ | last_host_q);
   assign pick_host = HOST_REQ & ~pick_eng;
   assign host_rej  = pick_host & HOST_WR & RUN;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pick_eng)                   state_d = RD;
            else if (pick_host && !host_rej) state_d = HOST_WR ? WR : RD;
         end
         WR:      state_d = IDLE;
         RD:      state_d = RD_WAIT;
         RD_WAIT: if (cnt_q == 2'd0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      // NOTE: every _d gets a default before the case so no path can infer a latch.
      cnt_d           = cnt_q;
      owner_eng_d     = owner_eng_q;
      last_host_d     = last_host_q;
      eng_elig_d      = eng_elig_q | ~ENG_REQ;
      sram_addr_d     = sram_addr_q;
      sram_cs_d       = 1'b0;
      sram_wr_d       = 1'b0;
      sram_wr_dat_d   = '0;
      sram_byteen_d   = '0;
      host_gnt_d      = 1'b0;
      host_err_d      = 1'b0;
      host_rd_valid_d = 1'b0;
      host_rd_dat_d   = host_rd_dat_q;
      eng_ack_d       = 1'b0;
      eng_rd_dat_d    = eng_rd_dat_q;
      case (state_q)
         IDLE: begin
            if (pick_eng) begin
               owner_eng_d   = 1'b1;
               last_host_d   = 1'b0;
               sram_cs_d     = 1'b1;
               sram_addr_d   = ENG_ADDR;
               sram_byteen_d = '1;
            end else if (pick_host) begin
               last_host_d = 1'b1;
               if (host_rej) begin
                  host_err_d = 1'b1;
               end else begin
                  owner_eng_d = 1'b0;
                  host_gnt_d  = 1'b1;
                  sram_cs_d   = 1'b1;
                  sram_addr_d = HOST_ADDR;
                  if (HOST_WR) begin
                     sram_wr_d     = 1'b1;
                     sram_wr_dat_d = HOST_WR_DAT;
                     sram_byteen_d = HOST_BYTEEN;
                  end else begin
                     sram_byteen_d = '1;
                  end
               end
            end
         end
         RD: cnt_d = WAIT_INIT;
         RD_WAIT: begin
            if (cnt_q == 2'd0) begin
               if (owner_eng_q) begin
                  eng_ack_d    = 1'b1;
                  eng_rd_dat_d = SRAM_RD_DAT;
                  eng_elig_d   = 1'b0;
               end else begin
                  host_rd_valid_d = 1'b1;
                  host_rd_dat_d   = SRAM_RD_DAT;
               end
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q           <= 2'd0;
         owner_eng_q     <= 1'b0;
         last_host_q     <= 1'b1;
         eng_elig_q      <= 1'b1;
         sram_addr_q     <= '0;
         sram_cs_q       <= 1'b0;
         sram_wr_q       <= 1'b0;
         sram_wr_dat_q   <= '0;
         sram_byteen_q   <= '0;
         host_gnt_q      <= 1'b0;
         host_err_q      <= 1'b0;
         host_rd_valid_q <= 1'b0;
         host_rd_dat_q   <= '0;
         eng_ack_q       <= 1'b0;
         eng_rd_dat_q    <= '0;
      end else begin
         cnt_q           <= cnt_d;
         owner_eng_q     <= owner_eng_d;
         last_host_q     <= last_host_d;
         eng_elig_q      <= eng_elig_d;
         sram_addr_q     <= sram_addr_d;
         sram_cs_q       <= sram_cs_d;
         sram_wr_q       <= sram_wr_d;
         sram_wr_dat_q   <= sram_wr_dat_d;
         sram_byteen_q   <= sram_byteen_d;
         host_gnt_q      <= host_gnt_d;
         host_err_q      <= host_err_d;
         host_rd_valid_q <= host_rd_valid_d;
         host_rd_dat_q   <= host_rd_dat_d;
         eng_ack_q       <= eng_ack_d;
         eng_rd_dat_q    <= eng_rd_dat_d;
      end
   end

   assign SRAM_ADDR     = sram_addr_q;
   assign SRAM_CS       = sram_cs_q;
   assign SRAM_CLKEN    = sram_cs_q;
   assign SRAM_WR       = sram_wr_q;
   assign SRAM_WR_DAT   = sram_wr_dat_q;
   assign SRAM_BYTEEN   = sram_byteen_q;
   assign HOST_GNT      = host_gnt_q;
   assign HOST_ERR      = host_err_q;
   assign HOST_RD_VALID = host_rd_valid_q;
   assign HOST_RD_DAT   = host_rd_dat_q;
   assign ENG_ACK       = eng_ack_q;
   assign ENG_RD_DAT    = eng_rd_dat_q;

endmodule

// File: tb/tb_nmr_bstrm_sram_arb.sv
// Bench for nmr_bstrm_sram_arb: behavioural SRAM plus a transaction-level schedule model
// that predicts every output cycle by cycle under directed and random stimulus.
module tb_nmr_bstrm_sram_arb;

   localparam int AW = 8;
   localparam int DW = 128;
   localparam int BW = 16;
   localparam int RD_LAT = 2;
   localparam logic [DW-1:0] ENG_WORD =
      (128'd5 << 96) | (128'd8 << 64) | (128'd5 << 32) | (128'd4 << 16) | 128'd2;
   localparam logic [7:0] TAG_E = 8'h45;
   localparam logic [7:0] TAG_H = 8'h48;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          RUN = 1'b0;
   logic          HOST_REQ = 1'b0;
   logic          HOST_WR = 1'b0;
   logic [AW-1:0] HOST_ADDR = '0;
   logic [DW-1:0] HOST_WR_DAT = '0;
   logic [BW-1:0] HOST_BYTEEN = '0;
   logic          HOST_GNT, HOST_ERR, HOST_RD_VALID;
   logic [DW-1:0] HOST_RD_DAT;
   logic          ENG_REQ = 1'b0;
   logic [AW-1:0] ENG_ADDR = '0;
   logic          ENG_ACK;
   logic [DW-1:0] ENG_RD_DAT;
   logic [AW-1:0] SRAM_ADDR;
   logic          SRAM_CS, SRAM_CLKEN, SRAM_WR;
   logic [DW-1:0] SRAM_WR_DAT;
   logic [BW-1:0] SRAM_BYTEEN;
   logic [DW-1:0] SRAM_RD_DAT;

   nmr_bstrm_sram_arb #(
      .SRAM_ADDR_WIDTH(AW), .SRAM_DAT_WIDTH(DW), .SRAM_BYTEEN_WIDTH(BW), .RD_LAT(RD_LAT)
   ) dut (
      .CLK(CLK), .RST(RST), .RUN(RUN),
      .HOST_REQ(HOST_REQ), .HOST_WR(HOST_WR), .HOST_ADDR(HOST_ADDR),
      .HOST_WR_DAT(HOST_WR_DAT), .HOST_BYTEEN(HOST_BYTEEN),
      .HOST_GNT(HOST_GNT), .HOST_ERR(HOST_ERR), .HOST_RD_VALID(HOST_RD_VALID),
      .HOST_RD_DAT(HOST_RD_DAT),
      .ENG_REQ(ENG_REQ), .ENG_ADDR(ENG_ADDR), .ENG_ACK(ENG_ACK), .ENG_RD_DAT(ENG_RD_DAT),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_CS(SRAM_CS), .SRAM_CLKEN(SRAM_CLKEN), .SRAM_WR(SRAM_WR),
      .SRAM_WR_DAT(SRAM_WR_DAT), .SRAM_BYTEEN(SRAM_BYTEEN), .SRAM_RD_DAT(SRAM_RD_DAT)
   );

   always #5 CLK = ~CLK;

   function automatic logic [DW-1:0] init_word(input int i);
      logic [31:0] a;
      a = 32'(i) * 32'h9E37_79B9;
      if (i == 3) return ENG_WORD;
      return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd17};
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                           input logic [BW-1:0] be);
      logic [DW-1:0] r;
      r = old;
      for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   // Behavioural SRAM: samples address on the edge ending a CS cycle, data appears RD_LAT later.
   logic [DW-1:0] sram_mem [256];
   logic [DW-1:0] rd_pipe [3];
   bit            mem_ready = 1'b0;

   always @(posedge CLK) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) sram_mem[i] = init_word(i);
         mem_ready = 1'b1;
      end
      rd_pipe[0] <= (SRAM_CS && !SRAM_WR) ? sram_mem[SRAM_ADDR]
                                          : {$urandom, $urandom, $urandom, $urandom};
      rd_pipe[1] <= rd_pipe[0];
      rd_pipe[2] <= rd_pipe[1];
      if (SRAM_CS && SRAM_WR) sram_mem[SRAM_ADDR] = merge(sram_mem[SRAM_ADDR], SRAM_WR_DAT, SRAM_BYTEEN);
   end
   assign SRAM_RD_DAT = rd_pipe[RD_LAT-1];

   // Reference model: expected outputs scheduled into a ring indexed by cycle.
   typedef struct packed {
      logic          cs, wr, gnt, err, rdv, ack, set_h, set_e, cm;
      logic [AW-1:0] addr, cm_addr;
      logic [DW-1:0] wdat, hdat, edat, cm_dat;
      logic [BW-1:0] be, cm_be;
   } exp_t;

   exp_t          ring [8];
   logic [DW-1:0] model_mem [256];
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_hdat, exp_edat;
   int  n_checks = 0, n_fail = 0;
   int  cyc = 0, free_at = 0, last_ack = -1, last_low = -1;
   bit  last_host = 1'b1, ack_drop = 1'b0;
   int  n_cs = 0, n_wr = 0, n_gnt = 0, n_err = 0, n_ack = 0, cs_cyc = 0, ack_cyc = 0;
   logic [7:0] order_q [$];

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic check_zero_outputs();
      check("rst_sram_cs", DW'(SRAM_CS), '0);
      check("rst_sram_clken", DW'(SRAM_CLKEN), '0);
      check("rst_sram_wr", DW'(SRAM_WR), '0);
      check("rst_sram_addr", DW'(SRAM_ADDR), '0);
      check("rst_sram_wr_dat", SRAM_WR_DAT, '0);
      check("rst_sram_byteen", DW'(SRAM_BYTEEN), '0);
      check("rst_host_gnt", DW'(HOST_GNT), '0);
      check("rst_host_err", DW'(HOST_ERR), '0);
      check("rst_host_rd_valid", DW'(HOST_RD_VALID), '0);
      check("rst_host_rd_dat", HOST_RD_DAT, '0);
      check("rst_eng_ack", DW'(ENG_ACK), '0);
      check("rst_eng_rd_dat", ENG_RD_DAT, '0);
   endtask

   task automatic check_outputs();
      int   s;
      exp_t e;
      s = cyc % 8;
      e = ring[s];
      if (e.cs)    exp_addr = e.addr;
      if (e.set_h) exp_hdat = e.hdat;
      if (e.set_e) exp_edat = e.edat;
      if (e.cm)    model_mem[e.cm_addr] = merge(model_mem[e.cm_addr], e.cm_dat, e.cm_be);
      check("sram_cs", DW'(SRAM_CS), DW'(e.cs));
      check("sram_clken", DW'(SRAM_CLKEN), DW'(e.cs));
      check("sram_wr", DW'(SRAM_WR), DW'(e.wr));
      check("sram_addr", DW'(SRAM_ADDR), DW'(exp_addr));
      check("sram_wr_dat", SRAM_WR_DAT, e.wdat);
      check("sram_byteen", DW'(SRAM_BYTEEN), DW'(e.be));
      check("host_gnt", DW'(HOST_GNT), DW'(e.gnt));
      check("host_err", DW'(HOST_ERR), DW'(e.err));
      check("host_rd_valid", DW'(HOST_RD_VALID), DW'(e.rdv));
      check("host_rd_dat", HOST_RD_DAT, exp_hdat);
      check("eng_ack", DW'(ENG_ACK), DW'(e.ack));
      check("eng_rd_dat", ENG_RD_DAT, exp_edat);
      if (SRAM_CS) begin n_cs++; cs_cyc = cyc; end
      if (SRAM_WR) n_wr++;
      if (HOST_GNT) n_gnt++;
      if (HOST_ERR) n_err++;
      if (ENG_ACK) begin n_ack++; ack_cyc = cyc; order_q.push_back(TAG_E); end
      if (HOST_RD_VALID) order_q.push_back(TAG_H);
      ring[s] = '0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) ring[i] = '0;
      exp_addr  = '0;
      exp_hdat  = '0;
      exp_edat  = '0;
      last_host = 1'b1;
      last_ack  = -1;
      last_low  = -1;
      free_at   = cyc;
   endtask

   // Decide what the arbiter does with the requests presented in the current cycle.
   task automatic model_cycle();
      int c, s1, s2, sa;
      bit eng_p;
      c  = cyc;
      s1 = (c + 1) % 8;
      s2 = (c + 2) % 8;
      sa = (c + 2 + RD_LAT) % 8;
      eng_p = ENG_REQ && (last_low >= last_ack);
      if (c >= free_at) begin
         if (eng_p && (!HOST_REQ || last_host)) begin
            last_host = 1'b0;
            ring[s1].cs = 1'b1; ring[s1].addr = ENG_ADDR; ring[s1].be = '1;
            ring[sa].ack = 1'b1; ring[sa].set_e = 1'b1; ring[sa].edat = model_mem[ENG_ADDR];
            last_ack = c + 2 + RD_LAT;
            free_at  = c + 2 + RD_LAT;
         end else if (HOST_REQ) begin
            last_host = 1'b1;
            if (HOST_WR && RUN) begin
               ring[s1].err = 1'b1;
               free_at = c + 1;
            end else begin
               ring[s1].cs = 1'b1; ring[s1].gnt = 1'b1; ring[s1].addr = HOST_ADDR;
               if (HOST_WR) begin
                  ring[s1].wr = 1'b1; ring[s1].wdat = HOST_WR_DAT; ring[s1].be = HOST_BYTEEN;
                  ring[s2].cm = 1'b1; ring[s2].cm_addr = HOST_ADDR;
                  ring[s2].cm_dat = HOST_WR_DAT; ring[s2].cm_be = HOST_BYTEEN;
                  free_at = c + 2;
               end else begin
                  ring[s1].be = '1;
                  ring[sa].rdv = 1'b1; ring[sa].set_h = 1'b1; ring[sa].hdat = model_mem[HOST_ADDR];
                  free_at = c + 2 + RD_LAT;
               end
            end
         end
      end
      if (!ENG_REQ) last_low = c;
   endtask

   task automatic step(input logic run_i, input logic hreq_i, input logic hwr_i,
                       input logic [AW-1:0] haddr_i, input logic [DW-1:0] hdat_i,
                       input logic [BW-1:0] hbe_i, input logic ereq_i, input logic [AW-1:0] eaddr_i);
      @(posedge CLK);
      #1;
      cyc++;
      check_outputs();
      RUN         = run_i;
      HOST_REQ    = hreq_i;
      HOST_WR     = hwr_i;
      HOST_ADDR   = haddr_i;
      HOST_WR_DAT = hdat_i;
      HOST_BYTEEN = hbe_i;
      ENG_REQ     = (ack_drop && ENG_ACK) ? 1'b0 : ereq_i;
      ENG_ADDR    = eaddr_i;
      model_cycle();
   endtask

   task automatic idle_steps(input logic run_i, input int n);
      for (int i = 0; i < n; i++) step(run_i, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      #1;
      check_zero_outputs();
      @(posedge CLK);
      #1;
      cyc++;
      RST = 1'b0;
      model_reset();
      check_outputs();
      RUN = 1'b0; HOST_REQ = 1'b0; HOST_WR = 1'b0; ENG_REQ = 1'b0;
      model_cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap_cs, snap_wr, snap_gnt, snap_err, snap_ack;
      logic run_r;
      for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
      #2;
      do_reset();

      // Engine fetch with a held request: one access, ACK RD_LAT+1 cycles after CS.
      snap_cs = n_cs; snap_ack = n_ack;
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 8'h03);
      check("eng_single_access", DW'(n_cs - snap_cs), DW'(1));
      check("eng_single_ack", DW'(n_ack - snap_ack), DW'(1));
      check("eng_ack_latency", DW'(ack_cyc - cs_cyc), DW'(RD_LAT + 1));
      check("eng_word", ENG_RD_DAT, ENG_WORD);

      // Host write while idle.
      snap_wr = n_wr; snap_gnt = n_gnt; snap_err = n_err;
      step(1'b0, 1'b1, 1'b1, 8'h10, {4{32'hCAFE_0123}}, 16'hFFFF, 1'b0, '0);
      idle_steps(1'b0, 4);
      check("wr_idle_wr_cycles", DW'(n_wr - snap_wr), DW'(1));
      check("wr_idle_gnt_cycles", DW'(n_gnt - snap_gnt), DW'(1));
      check("wr_idle_err_cycles", DW'(n_err - snap_err), DW'(0));

      // Host write during run is rejected.
      snap_cs = n_cs; snap_err = n_err;
      step(1'b1, 1'b1, 1'b1, 8'h10, {4{32'h0BAD_0BAD}}, 16'hFFFF, 1'b0, '0);
      idle_steps(1'b1, 4);
      check("wr_run_err_cycles", DW'(n_err - snap_err), DW'(1));
      check("wr_run_cs_cycles", DW'(n_cs - snap_cs), DW'(0));

      // Contention after reset: engine first, then strict alternation.
      do_reset();
      order_q.delete();
      ack_drop = 1'b1;
      for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 8'h10, '0, '0, 1'b1, 8'h03);
      ack_drop = 1'b0;
      check("rr_order_0", DW'(order_q[0]), DW'(TAG_E));
      check("rr_order_1", DW'(order_q[1]), DW'(TAG_H));
      check("rr_order_2", DW'(order_q[2]), DW'(TAG_E));
      check("rr_order_3", DW'(order_q[3]), DW'(TAG_H));

      // Reset during RD_WAIT aborts the fetch.
      do_reset();
      step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 8'h07);
      step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 8'h07);
      step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 8'h07);
      do_reset();
      snap_ack = n_ack;
      idle_steps(1'b0, 8);
      check("rst_abort_no_ack", DW'(n_ack - snap_ack), DW'(0));

      // Random traffic against the model.
      run_r = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) run_r = ~run_r;
         if ($urandom_range(0, 399) == 0) do_reset();
         else step(run_r, $urandom_range(0, 99) < 40, 1'($urandom_range(0, 1)),
                   AW'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom},
                   BW'($urandom), $urandom_range(0, 99) < 60, AW'($urandom_range(0, 15)));
      end
      idle_steps(1'b0, 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
